// File: rtl/ladybird_config_pkg.sv
// Shared ladybird bus types: master/slave enumerations, address decode and
// the request/response records used by the bus router.
package ladybird_config;

  localparam int XLEN                = 32;
  localparam int NUM_PERIPHERAL      = 6;
  localparam int BUS_TIMEOUT_DEFAULT = 1024;

  typedef enum logic {
    D_BUS = 1'b0,
    I_BUS = 1'b1
  } core_bus_t;

  typedef enum logic [2:0] {
    IRAM = 3'd0,
    BRAM = 3'd1,
    DRAM = 3'd2,
    UART = 3'd3,
    QSPI = 3'd4,
    GPIO = 3'd5
  } access_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } router_state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            we;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] wdata;
  } bus_req_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            err;
  } bus_resp_t;

  // Top nibble selects the region; anything unmapped lands in DRAM.
  function automatic access_t ACCESS_TYPE(input logic [XLEN-1:0] addr);
    case (addr[XLEN-1 -: 4])
      4'h9:    return IRAM;
      4'h8:    return BRAM;
      4'hF:    return UART;
      4'hD:    return QSPI;
      4'hE:    return GPIO;
      default: return DRAM;
    endcase
  endfunction

endpackage

// File: rtl/ladybird_bus_router_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the master that was not granted last time.
module ladybird_rr_arbiter2
  import ladybird_config::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic [1:0] req,
  input  logic      accept,
  output core_bus_t grant,
  output logic      grant_valid
);

  core_bus_t last_grant;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    grant       = D_BUS;
    grant_valid = |req;
    if (req[D_BUS] && req[I_BUS]) begin
      grant = (last_grant == D_BUS) ? I_BUS : D_BUS;
    end else if (req[I_BUS]) begin
      grant = I_BUS;
    end
  end

  // Starts as I_BUS so the first tie after reset goes to D_BUS.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      last_grant <= I_BUS;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/ladybird_bus_router.sv
// Routes one D_BUS/I_BUS transaction at a time to the decoded peripheral and
// returns its response; a watchdog turns a hung slave into an error response.
module ladybird_bus_router
  import ladybird_config::*;
#(
  parameter int unsigned     TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT,
  parameter logic [XLEN-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [1:0]                           m_req_valid,
  output logic [1:0]                           m_req_ready,
  input  logic [1:0][XLEN-1:0]                 m_req_addr,
  input  logic [1:0]                           m_req_we,
  input  logic [1:0][3:0]                      m_req_wstrb,
  input  logic [1:0][XLEN-1:0]                 m_req_wdata,
  output logic [1:0]                           m_resp_valid,
  output logic [XLEN-1:0]                      m_resp_data,
  output logic                                 m_resp_err,
  output logic [NUM_PERIPHERAL-1:0]            s_req_valid,
  input  logic [NUM_PERIPHERAL-1:0]            s_req_ready,
  output logic [XLEN-1:0]                      s_req_addr,
  output logic                                 s_req_we,
  output logic [3:0]                           s_req_wstrb,
  output logic [XLEN-1:0]                      s_req_wdata,
  input  logic [NUM_PERIPHERAL-1:0]            s_resp_valid,
  input  logic [NUM_PERIPHERAL-1:0][XLEN-1:0]  s_resp_data
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  router_state_t state, state_nxt;
  core_bus_t     arb_grant, grant_q;
  logic          arb_valid;
  access_t       target_q;
  bus_req_t      req_q;
  bus_resp_t     resp_q;
  logic          resp_pulse_q;
  logic [CW-1:0] wd_cnt;
  logic          wd_expired;
  logic          load, complete, timeout_hit;

  ladybird_rr_arbiter2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (m_req_valid),
    .accept      (load),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  assign wd_expired = (wd_cnt == CNT_LAST);

  // The watchdog wins over a slave response arriving on its final cycle.
  always_comb begin
    state_nxt   = state;
    m_req_ready = '0;
    s_req_valid = '0;
    load        = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          load                   = 1'b1;
          m_req_ready[arb_grant] = 1'b1;
          state_nxt              = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wd_expired) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          s_req_valid[target_q] = 1'b1;
          if (s_req_ready[target_q]) begin
            if (s_resp_valid[target_q]) begin
              complete  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_RESP;
            end
          end
        end
      end
      ST_RESP: begin
        if (wd_expired) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end else if (s_resp_valid[target_q]) begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      m_req_ready = '0;
      s_req_valid = '0;
      load        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      grant_q      <= D_BUS;
      target_q     <= IRAM;
      req_q        <= '0;
      resp_q       <= '0;
      resp_pulse_q <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      state        <= state_nxt;
      resp_pulse_q <= complete | timeout_hit;
      if (load) begin
        grant_q  <= arb_grant;
        target_q <= ACCESS_TYPE(m_req_addr[arb_grant]);
        req_q    <= '{addr:  m_req_addr[arb_grant],
                      we:    m_req_we[arb_grant],
                      wstrb: m_req_wstrb[arb_grant],
                      wdata: m_req_wdata[arb_grant]};
        wd_cnt   <= '0;
      end else if (state != ST_IDLE) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (timeout_hit) begin
        resp_q <= '{data: TIMEOUT_DATA, err: 1'b1};
      end else if (complete) begin
        resp_q <= '{data: s_resp_data[target_q], err: 1'b0};
      end
    end
  end

  // grant_q still names the finished transaction during the pulse, even if a
  // new grant is being made in that same cycle.
  always_comb begin
    m_resp_valid = '0;
    if (resp_pulse_q) m_resp_valid[grant_q] = 1'b1;
  end

  assign m_resp_data = resp_q.data;
  assign m_resp_err  = resp_pulse_q & resp_q.err;
  assign s_req_addr  = req_q.addr;
  assign s_req_we    = req_q.we;
  assign s_req_wstrb = req_q.wstrb;
  assign s_req_wdata = req_q.wdata;

endmodule

// File: doc/ladybird_bus_router.md
Name: ladybird_bus_router

Overview:
- Sits between the core's two bus ports (D_BUS, I_BUS) and the NUM_PERIPHERAL slaves (IRAM, BRAM, DRAM, UART, QSPI, GPIO).
- Arbitrates the two masters, decodes the target with ACCESS_TYPE on the request address, and forwards the request to exactly one slave.
- Returns that slave's response to the granted master.
- One transaction in flight at a time; a watchdog converts a hung slave into an error response.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles waited in REQ or RESP before an error response is forced (must be ≥2).
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m_req_valid  in  [2]  request valid, indexed by core_bus_t
- m_req_ready  out  [2]  request accepted this cycle
- m_req_addr  in  [2][XLEN]  byte address
- m_req_we  in  [2]  1 = write
- m_req_wstrb  in  [2][4]  byte enables
- m_req_wdata  in  [2][XLEN]  write data
- m_resp_valid  out  [2]  one-cycle response pulse
- m_resp_data  out  XLEN  read data (shared; qualify with m_resp_valid)
- m_resp_err  out  1  response was a timeout
- s_req_valid  out  [NUM_PERIPHERAL]  request to slave, indexed by access_t
- s_req_ready  in  [NUM_PERIPHERAL]  slave accepted
- s_req_addr / s_req_we / s_req_wstrb / s_req_wdata  out  XLEN/1/4/XLEN  shared, registered request fields
- s_resp_valid  in  [NUM_PERIPHERAL]  slave response pulse
- s_resp_data  in  [NUM_PERIPHERAL][XLEN]  slave read data

Behaviour:
- Reset: state IDLE; last_grant = I_BUS, so D_BUS wins the first tie. All outputs read 0: m_req_ready, m_resp_valid, m_resp_err, s_req_valid, and the registered s_req_* fields.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any m_req_valid is set, grant one master. A single requester gets the grant. On a tie, the master not in last_grant wins (round-robin).
  - m_req_ready[grant] = 1 combinationally in that same cycle. This is the only cycle m_req_ready is high.
  - Latch addr/we/wstrb/wdata, grant and target = ACCESS_TYPE(addr); update last_grant; go to REQ.
- REQ:
  - s_req_valid[target] = 1; every other bit is 0.
  - On s_req_ready[target], go to RESP.
  - If s_resp_valid[target] arrives in the same cycle as s_req_ready, treat it as the response: skip RESP and complete immediately.
- RESP: wait for s_resp_valid[target]. Responses from any other slave are ignored.
- Completion:
  - Next cycle, m_resp_valid[grant] = 1 for exactly one cycle, with m_resp_data = the latched s_resp_data[target] and m_resp_err = 0.
  - Return to IDLE. A new grant may occur in that same IDLE cycle.
- Writes also wait for s_resp_valid as their acknowledgement; data is don't-care.
- Minimum latency, request accept to m_resp_valid: 2 cycles (slave ready and response both at REQ entry). For a 0-wait slave the sequence is:
  - accept (IDLE)
  - REQ with ready + resp
  - m_resp_valid
- Watchdog:
  - Counter clears on entry to REQ and counts in REQ and RESP.
  - Reaching TIMEOUT_CYCLES-1 forces completion with m_resp_data = TIMEOUT_DATA and m_resp_err = 1, deasserts s_req_valid, and returns to IDLE.
  - A late slave response arriving in IDLE is dropped.
- Address decode is fully covered by ACCESS_TYPE, since the default is DRAM. Unaligned addresses are passed through unchanged; checking them is the core's job.
- rst mid-transaction: return to IDLE next cycle, drop the transaction with no response, and clear all outputs. The slave must also be reset.
- m_req_* fields of a non-granted master are ignored; its valid stays pending.

Decomposition:
- ladybird_config additions:
  - typedef bus_req_t (addr, we, wstrb, wdata)
  - typedef bus_resp_t (data, err)
  - localparam BUS_TIMEOUT_DEFAULT = 1024
- Reuse the existing core_bus_t, access_t, NUM_PERIPHERAL and ACCESS_TYPE.
- One natural sub-module: ladybird_rr_arbiter2 (2-way round-robin with a last_grant register).

Test Plan:
- Single read: I_BUS reads 0x9000_0010 from IRAM. IRAM ready and resp in the REQ cycle with data 0x0000_0013 → s_req_valid[IRAM] for one cycle; m_resp_valid[I_BUS] pulses 2 cycles after accept with data 0x0000_0013, err 0.
- Decode sweep: D_BUS reads 0xF000_0000, 0xE000_0004, 0xD000_0000, 0x8000_0000, 0x0000_1000 → s_req_valid selects UART, GPIO, QSPI, BRAM, DRAM respectively.
- Arbitration: both masters valid every cycle from reset, every slave 0-wait → grants alternate D, I, D, I over 4 transactions; no starvation.
- Wait states: DRAM write to 0x1000_0000, wstrb 4'b0011, wdata 0x1234_5678. Ready after 3 cycles, resp 5 cycles later → s_req_* stable throughout; exactly one m_resp_valid[D_BUS].
- Timeout: TIMEOUT_CYCLES = 16, and the UART never raises ready → m_resp_valid[D_BUS] with err = 1 and data 0xDEAD_BEEF exactly 16 cycles after REQ entry. The next request is serviced normally.
- Reset mid-RESP: assert rst while waiting on QSPI → no m_resp_valid; all outputs 0 the next cycle; the first post-reset tie is granted to D_BUS.
